// File: rtl/rf_pkg.sv
// Shared definitions for the register-file port controller.
// Default widths, read FSM states and the hardwired-zero address.
package rf_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        RD_ISSUE,
        RD_CAPT,
        RD_RESP
    } rd_state_t;

    localparam logic [DEF_ADDR_W-1:0] ZERO_ADDR = '0;

endpackage

// File: rtl/regfile_port_ctrl.sv
// Valid/ready front end for the 32x32 register file: write pulse,
// dual read with registered-output latency, and held read response.
module regfile_port_ctrl
    import rf_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter bit ZERO_REG_WE = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data1,
    output logic [DATA_W-1:0] rsp_data2,
    output logic [ADDR_W-1:0] rf_r1_addr,
    output logic [ADDR_W-1:0] rf_r2_addr,
    output logic [ADDR_W-1:0] rf_w_addr,
    output logic [DATA_W-1:0] rf_w_data,
    output logic              rf_we,
    input  logic [DATA_W-1:0] rf_r1_out,
    input  logic [DATA_W-1:0] rf_r2_out,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_ADDR);

    rd_state_t state, state_nxt;

    logic wr_fire;
    logic rd_fire;
    logic rsp_fire;
    logic capt_en;
    logic zero1;
    logic zero2;
    logic wr_keep;

    assign wr_ready = (state == IDLE) || (state == RD_RESP);
    assign rd_ready = (state == IDLE) && !wr_valid;

    assign wr_fire  = wr_valid && wr_ready;
    assign rd_fire  = rd_valid && rd_ready;
    assign rsp_fire = rsp_valid && rsp_ready;

    // Writes to r0 still handshake but never reach the file.
    assign wr_keep = ZERO_REG_WE || (wr_addr != ZERO_A);
    assign zero1   = !ZERO_REG_WE && (rf_r1_addr == ZERO_A);
    assign zero2   = !ZERO_REG_WE && (rf_r2_addr == ZERO_A);

    assign busy = (state != IDLE) || rf_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (rd_fire) state_nxt = RD_ISSUE;
            RD_ISSUE: state_nxt = RD_CAPT;
            RD_CAPT:  state_nxt = RD_RESP;
            RD_RESP:  if (rsp_fire) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rsp_valid = 1'b0;
        capt_en   = 1'b0;
        unique case (state)
            RD_CAPT: capt_en   = 1'b1;
            RD_RESP: rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_r1_addr <= '0;
            rf_r2_addr <= '0;
        end else if (rd_fire) begin
            rf_r1_addr <= rd_addr1;
            rf_r2_addr <= rd_addr2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data1 <= '0;
            rsp_data2 <= '0;
        end else if (capt_en) begin
            rsp_data1 <= zero1 ? '0 : rf_r1_out;
            rsp_data2 <= zero2 ? '0 : rf_r2_out;
        end
    end

    // rf_we is a single-cycle pulse per accepted write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_w_addr <= '0;
            rf_w_data <= '0;
            rf_we     <= 1'b0;
        end else begin
            rf_we <= wr_fire && wr_keep;
            if (wr_fire) begin
                rf_w_addr <= wr_addr;
                rf_w_data <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Scoreboard bench: two controllers (r0 hardwired / ordinary) on
// shared stimulus, each driving its own behavioural register file.
module tb_regfile_port_ctrl;
    import rf_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid, rd_valid, rsp_ready;
    logic [4:0]  wr_addr, rd_addr1, rd_addr2;
    logic [31:0] wr_data;

    logic        wr_ready0, rd_ready0, rsp_valid0, rf_we0, busy0;
    logic        wr_ready1, rd_ready1, rsp_valid1, rf_we1, busy1;
    logic [31:0] rsp_data10, rsp_data20, rf_w_data0, rf_r1_out0, rf_r2_out0;
    logic [31:0] rsp_data11, rsp_data21, rf_w_data1, rf_r1_out1, rf_r2_out1;
    logic [4:0]  rf_r1_addr0, rf_r2_addr0, rf_w_addr0;
    logic [4:0]  rf_r1_addr1, rf_r2_addr1, rf_w_addr1;

    always #5 clk = ~clk;

    regfile_port_ctrl #(.ADDR_W(5), .DATA_W(32), .ZERO_REG_WE(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready0),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready0),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready),
        .rsp_data1(rsp_data10), .rsp_data2(rsp_data20),
        .rf_r1_addr(rf_r1_addr0), .rf_r2_addr(rf_r2_addr0),
        .rf_w_addr(rf_w_addr0), .rf_w_data(rf_w_data0), .rf_we(rf_we0),
        .rf_r1_out(rf_r1_out0), .rf_r2_out(rf_r2_out0), .busy(busy0)
    );

    regfile_port_ctrl #(.ADDR_W(5), .DATA_W(32), .ZERO_REG_WE(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready1),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready1),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready),
        .rsp_data1(rsp_data11), .rsp_data2(rsp_data21),
        .rf_r1_addr(rf_r1_addr1), .rf_r2_addr(rf_r2_addr1),
        .rf_w_addr(rf_w_addr1), .rf_w_data(rf_w_data1), .rf_we(rf_we1),
        .rf_r1_out(rf_r1_out1), .rf_r2_out(rf_r2_out1), .busy(busy1)
    );

    // Register files: outputs registered, refreshed only when not writing.
    logic [31:0] rf0 [32];
    logic [31:0] rf1 [32];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf0[i] <= '0;
            rf_r1_out0 <= '0;
            rf_r2_out0 <= '0;
        end else if (rf_we0) begin
            rf0[rf_w_addr0] <= rf_w_data0;
        end else begin
            rf_r1_out0 <= rf0[rf_r1_addr0];
            rf_r2_out0 <= rf0[rf_r2_addr0];
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf1[i] <= '0;
            rf_r1_out1 <= '0;
            rf_r2_out1 <= '0;
        end else if (rf_we1) begin
            rf1[rf_w_addr1] <= rf_w_data1;
        end else begin
            rf_r1_out1 <= rf1[rf_r1_addr1];
            rf_r2_out1 <= rf1[rf_r2_addr1];
        end
    end

    typedef struct {
        logic [31:0] a0, b0, a1, b1;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m0 [32];
    logic [31:0] m1 [32];
    int          vec = 0;
    int          mis = 0;
    bit          pending, ewe0, ewe1;
    int          age;
    logic [4:0]  ewa;
    logic [31:0] ewd;
    bit          xw, xr, xs;
    exp_t        e;

    // Monitor: protocol model (outstanding read + age) and data scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            pending = 0; age = 0; ewe0 = 0; ewe1 = 0;
            q.delete();
            for (int i = 0; i < 32; i++) begin
                m0[i] = '0;
                m1[i] = '0;
            end
            vec++;
            if ({rsp_valid0, rsp_data10, rsp_data20, rf_r1_addr0, rf_r2_addr0,
                 rf_w_addr0, rf_w_data0, rf_we0, busy0} !== '0) begin
                mis++;
                $display("FAIL reset0 got v=%b d=%h/%h ra=%h/%h wa=%h wd=%h we=%b busy=%b want all 0",
                    rsp_valid0, rsp_data10, rsp_data20, rf_r1_addr0, rf_r2_addr0,
                    rf_w_addr0, rf_w_data0, rf_we0, busy0);
            end
            vec++;
            if ({rsp_valid1, rsp_data11, rsp_data21, rf_r1_addr1, rf_r2_addr1,
                 rf_w_addr1, rf_w_data1, rf_we1, busy1} !== '0) begin
                mis++;
                $display("FAIL reset1 got nonzero outputs, want all 0");
            end
        end else begin
            if (pending) age++;
            xw = !(pending && age < 3);
            xs = pending && age >= 3;
            xr = !pending && !wr_valid;
            vec++;
            if ({wr_ready0, rd_ready0, rsp_valid0} !== {xw, xr, xs}) begin
                mis++;
                $display("FAIL hs0 wr/rd/rsp got %b%b%b want %b%b%b",
                    wr_ready0, rd_ready0, rsp_valid0, xw, xr, xs);
            end
            vec++;
            if ({wr_ready1, rd_ready1, rsp_valid1} !== {xw, xr, xs}) begin
                mis++;
                $display("FAIL hs1 wr/rd/rsp got %b%b%b want %b%b%b",
                    wr_ready1, rd_ready1, rsp_valid1, xw, xr, xs);
            end
            vec++;
            if ({busy0, busy1} !== {pending || ewe0, pending || ewe1}) begin
                mis++;
                $display("FAIL busy got %b%b want %b%b", busy0, busy1,
                    pending || ewe0, pending || ewe1);
            end
            vec++;
            if ({rf_we0, rf_we1} !== {ewe0, ewe1}) begin
                mis++;
                $display("FAIL rf_we got %b%b want %b%b", rf_we0, rf_we1, ewe0, ewe1);
            end
            if (ewe0) begin
                vec++;
                if ({rf_w_addr0, rf_w_data0} !== {ewa, ewd}) begin
                    mis++;
                    $display("FAIL wport0 got %h:%h want %h:%h",
                        rf_w_addr0, rf_w_data0, ewa, ewd);
                end
            end
            if (ewe1) begin
                vec++;
                if ({rf_w_addr1, rf_w_data1} !== {ewa, ewd}) begin
                    mis++;
                    $display("FAIL wport1 got %h:%h want %h:%h",
                        rf_w_addr1, rf_w_data1, ewa, ewd);
                end
            end
            if (xs) begin
                vec++;
                if (q.size() == 0) begin
                    mis++;
                    $display("FAIL rsp_queue got empty want entry");
                end else begin
                    if ({rsp_data10, rsp_data20} !== {q[0].a0, q[0].b0}) begin
                        mis++;
                        $display("FAIL rsp0 got %h/%h want %h/%h",
                            rsp_data10, rsp_data20, q[0].a0, q[0].b0);
                    end
                    vec++;
                    if ({rsp_data11, rsp_data21} !== {q[0].a1, q[0].b1}) begin
                        mis++;
                        $display("FAIL rsp1 got %h/%h want %h/%h",
                            rsp_data11, rsp_data21, q[0].a1, q[0].b1);
                    end
                    if (rsp_ready) begin
                        void'(q.pop_front());
                        pending = 0;
                    end
                end
            end
            ewe0 = 0;
            ewe1 = 0;
            if (wr_valid && xw) begin
                ewe1 = 1;
                ewa  = wr_addr;
                ewd  = wr_data;
                m1[wr_addr] = wr_data;
                if (wr_addr != 5'd0) begin
                    ewe0 = 1;
                    m0[wr_addr] = wr_data;
                end
            end
            if (rd_valid && xr) begin
                e.a0 = m0[rd_addr1];
                e.b0 = m0[rd_addr2];
                e.a1 = m1[rd_addr1];
                e.b1 = m1[rd_addr2];
                q.push_back(e);
                pending = 1;
                age = 0;
            end
        end
    end

    task automatic stall(input string nm);
        $display("FAIL timeout %s got no handshake want one within 40 cycles", nm);
        $fatal(1, "timeout");
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        int n = 0;
        @(posedge clk); #1;
        wr_valid = 1; wr_addr = a; wr_data = d;
        @(negedge clk);
        while (!wr_ready0 && n < 40) begin n++; @(negedge clk); end
        if (n >= 40) stall("wr");
        @(posedge clk); #1;
        wr_valid = 0;
    endtask

    // Finishes a read whose rd_valid is already up; optional write in RESP.
    task automatic rd_finish(input int hold, input bit dowr,
                             input logic [4:0] a, input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        while (!rd_ready0 && n < 40) begin n++; @(negedge clk); end
        if (n >= 40) stall("rd");
        @(posedge clk); #1;
        rd_valid = 0;
        n = 0;
        @(negedge clk);
        while (!rsp_valid0 && n < 40) begin n++; @(negedge clk); end
        if (n >= 40) stall("rsp");
        if (dowr) begin
            @(posedge clk); #1;
            wr_valid = 1; wr_addr = a; wr_data = d;
            @(posedge clk); #1;
            wr_valid = 0;
        end
        repeat (hold) @(posedge clk);
        @(posedge clk); #1;
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
        @(posedge clk); #1;
        rd_valid = 1; rd_addr1 = a1; rd_addr2 = a2; rsp_ready = 0;
        rd_finish(0, 0, 5'd0, 32'd0);
    endtask

    initial begin
        bit wa, ra;
        int n;
        wr_valid = 0; rd_valid = 0; rsp_ready = 0;
        wr_addr = '0; wr_data = '0; rd_addr1 = '0; rd_addr2 = '0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1;

        wr(5'd5, 32'hDEADBEEF);
        rd(5'd5, 5'd5);

        // Write and read together: write wins, read follows.
        @(posedge clk); #1;
        wr_valid = 1; wr_addr = 5'd7; wr_data = 32'h1234;
        rd_valid = 1; rd_addr1 = 5'd7; rd_addr2 = 5'd7; rsp_ready = 0;
        @(posedge clk); #1;
        wr_valid = 0;
        rd_finish(0, 0, 5'd0, 32'd0);

        wr(5'd3, 32'h11);
        @(posedge clk); #1;
        rd_valid = 1; rd_addr1 = 5'd3; rd_addr2 = 5'd5;
        rd_finish(5, 1, 5'd3, 32'hFFFFFFFF);
        rd(5'd3, 5'd3);

        wr(5'd0, 32'hAAAA5555);
        rd(5'd0, 5'd7);

        // Reset while the read sits in the capture state.
        @(posedge clk); #1;
        rd_valid = 1; rd_addr1 = 5'd5; rd_addr2 = 5'd5;
        n = 0;
        @(negedge clk);
        while (!rd_ready0 && n < 40) begin n++; @(negedge clk); end
        if (n >= 40) stall("rd_rst");
        @(posedge clk); #1;
        rd_valid = 0;
        @(posedge clk); #2;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1;
        rd(5'd5, 5'd5);

        // Back-to-back write burst.
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            wr_valid = 1; wr_addr = 5'(i); wr_data = $urandom;
        end
        @(posedge clk); #1;
        wr_valid = 0;
        for (int i = 1; i <= 8; i++) rd(5'(i), 5'(9 - i));

        // Random traffic; requests held until accepted.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            wa = wr_valid && wr_ready0;
            ra = rd_valid && rd_ready0;
            @(posedge clk); #1;
            if (!wr_valid || wa) begin
                wr_valid = ($urandom % 3) == 0;
                wr_addr  = 5'($urandom % 10);
                wr_data  = $urandom;
            end
            if (!rd_valid || ra) begin
                rd_valid = ($urandom % 2) == 0;
                rd_addr1 = 5'($urandom % 10);
                rd_addr2 = 5'($urandom % 10);
            end
            rsp_ready = ($urandom % 3) != 0;
        end
        @(posedge clk); #1;
        wr_valid = 0; rd_valid = 0; rsp_ready = 1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

endmodule
